// File: rtl/switch_debouncer_pkg.sv
// Shared board constants and channel state encoding for the switch debouncer.
//   CLK_HZ                 system clock frequency
//   DEBOUNCE_MS            required settle time of a switch level
//   DEFAULT_STABLE_CYCLES  clocks a new level must persist at CLK_HZ
//   ch_state_e             per-channel debounce FSM state
package switch_debouncer_pkg;

    localparam int unsigned CLK_HZ                = 100_000_000;
    localparam int unsigned DEBOUNCE_MS           = 10;
    localparam int unsigned DEFAULT_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_e;

endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stability counter, clean level and
// 1-cycle rise/fall strobes.
//   i_clk      system clock, rising edge
//   i_reset_n  synchronous active-low reset
//   i_switch   raw asynchronous switch level
//   o_switch   debounced level (registered)
//   o_rise     1-cycle strobe coincident with o_switch 0->1
//   o_fall     1-cycle strobe coincident with o_switch 1->0
module sw_debounce_ch
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_switch,
    output logic o_switch,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned          CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    ch_state_e        state,  state_d;
    logic [CNT_W-1:0] count,  count_d;
    logic             stable, stable_d;
    logic             rise,   rise_d;
    logic             fall,   fall_d;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            state  <= CH_IDLE;
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1  <= i_switch;
            sync2  <= sync1;
            state  <= state_d;
            count  <= count_d;
            stable <= stable_d;
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

    // PEND always holds count in 1..CNT_LAST, so the counter can never wrap.
    always_comb begin
        state_d  = state;
        count_d  = count;
        stable_d = stable;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        unique case (state)
            CH_IDLE: begin
                count_d = '0;
                if (sync2 != stable) begin
                    state_d = CH_PEND;
                    count_d = CNT_W'(1);
                end
            end
            CH_PEND: begin
                if (sync2 == stable) begin
                    // Excursion ended before qualifying: drop it silently.
                    state_d = CH_IDLE;
                    count_d = '0;
                end else if (count == CNT_LAST) begin
                    state_d  = CH_IDLE;
                    count_d  = '0;
                    stable_d = sync2;
                    rise_d   = sync2;
                    fall_d   = ~sync2;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            default: begin
                state_d = CH_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign o_switch = stable;
    assign o_rise   = rise;
    assign o_fall   = fall;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW raw board switches; channels are fully independent.
//   i_clk      system clock, rising edge
//   i_reset_n  synchronous active-low reset
//   i_switch   raw asynchronous switch levels
//   o_switch   debounced levels (registered)
//   o_rise     per-channel 1-cycle 0->1 strobes
//   o_fall     per-channel 1-cycle 1->0 strobes
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned NUM_SW        = 2,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NUM_SW-1:0] i_switch,
    output logic [NUM_SW-1:0] o_switch,
    output logic [NUM_SW-1:0] o_rise,
    output logic [NUM_SW-1:0] o_fall
);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        sw_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .i_clk    (i_clk),
            .i_reset_n(i_reset_n),
            .i_switch (i_switch[g]),
            .o_switch (o_switch[g]),
            .o_rise   (o_rise[g]),
            .o_fall   (o_fall[g])
        );
    end

endmodule
